io_read_port: RTL and testbench
===============================

Name: io_read_port

Overview:
- Responder end of the per-thread I/O stall handshake.
- Owns one single-entry receive buffer per hardware thread, filled by an external producer.
- When the datapath reads the port, it returns the data and raises IO_ready, or it drops IO_ready so the PC controller replays that thread's instruction.
- Sits between external I/O logic and the A/B operand read mux, and drives the controller's IO_ready input.

Parameters:
WORD_WIDTH, 36, width of data word
THREAD_COUNT, 8, number of hardware threads (buffers)
THREAD_ADDR_WIDTH, 3, width of thread index, ceil(log2(THREAD_COUNT))
INITIAL_THREAD, 0, thread number presented in the first cycle after reset

Ports:
clock  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
rden  in  1  current-thread instruction reads this port this cycle
ext_wren  in  1  external producer writes a word this cycle
ext_thread  in  THREAD_ADDR_WIDTH  target thread of ext write
ext_data  in  WORD_WIDTH  word to buffer
ext_full  out  THREAD_COUNT  per-thread buffer-full flags; producer writes only when the bit is 0
read_data  out  WORD_WIDTH  word returned to datapath
IO_ready  out  1  1 = access completed or no access; 0 = replay
current_thread  out  THREAD_ADDR_WIDTH  thread owning this cycle's rden

Behaviour:
Thread counter:
- current_thread resets to INITIAL_THREAD.
- Increments by 1 every cycle and wraps from THREAD_COUNT-1 to 0. Never stalls.
- rden in cycle t always belongs to current_thread in cycle t.

Reset (asynchronous):
- ext_full all 0, read_data 0, IO_ready 1.
- Buffer contents are don't-care.
- Assertion mid-operation discards all buffered words and any in-flight read result.

Read path (registered, latency 1):
- rden=1 and full[cur]=1: next cycle read_data = buf[cur], IO_ready = 1; full[cur] clears at the same edge.
- rden=1 and full[cur]=0: next cycle IO_ready = 0; read_data holds its previous value; no state change.
- rden=0: next cycle IO_ready = 1, read_data holds.
- IO_ready is only meaningful for the thread sampled one cycle earlier. The controller's own alignment delay handles this.

Write path:
- ext_wren=1 and full[ext_thread]=0: buf[ext_thread] <= ext_data, full[ext_thread] set at the edge.
- ext_wren=1 and full[ext_thread]=1: protocol violation. Write dropped, buffer and flag unchanged.
- ext_thread >= THREAD_COUNT: write ignored.

Simultaneous events:
- Write and read to the same thread, buffer empty: the read misses (IO_ready=0 next cycle) and the write lands. The thread's replay, THREAD_COUNT cycles later, hits.
- Write and read to the same thread, buffer full: the read consumes the old word, the full flag clears, and the write is dropped (it was a violation as sampled). Flag clear takes priority over set only in this case.
- Write and read to different threads are fully independent.

Each thread's buffer is 1-deep. No ordering exists between threads.

Optional Feature:
Macro IO_READ_PORT_OVERRUN_CHECK_EN.
- Defined:
  - Adds output overrun (THREAD_COUNT bits), reset 0.
  - Bit n is set sticky on any dropped write to thread n (full violation).
  - Adds input overrun_clear (1 bit); when 1 it clears all bits next edge, with set taking priority in the same cycle.
- Undefined: ports absent, drops silent.

Test Plan:
- Release reset with INITIAL_THREAD=0, THREAD_COUNT=8 -> current_thread sequence 0,1,...,7,0; ext_full=0x00; IO_ready=1.
- ext_wren thread 3, data 0x000000ABC; rden when current_thread=3 -> next cycle read_data=0x000000ABC, IO_ready=1, ext_full bit3 goes 1 then 0.
- rden at thread 5 with empty buffer -> next cycle IO_ready=0 and read_data unchanged. Fill thread 5 with 0x123 and rden again 8 cycles later -> read_data=0x123, IO_ready=1.
- Same cycle: ext_wren thread 2 data 0x55 and rden at thread 2 (empty) -> IO_ready=0 next cycle, ext_full bit2=1. Replay 8 cycles later returns 0x55.
- Write thread 6 with 0x11 then 0x22 while full -> buffer keeps 0x11. With macro defined, overrun bit6=1 until overrun_clear.
- Assert reset_n low mid-cycle with threads 1 and 4 full -> ext_full=0x00 and IO_ready=1 immediately, without waiting for a clock edge. current_thread returns to 0.

Source files
------------

// File: rtl/io_read_port_if.sv
// -----------------------------------------------------------------------------
// io_read_port_if
// Groups the per-thread I/O read-port signals: the datapath read request,
// the external producer's write channel and the responder's replies.
//
//   rden           datapath -> port   current-thread instruction reads the port
//   ext_wren       producer -> port   producer writes a word this cycle
//   ext_thread     producer -> port   target thread of the producer write
//   ext_data       producer -> port   word to buffer
//   ext_full       port -> producer   per-thread buffer-full flags
//   read_data      port -> datapath   word returned to the datapath
//   IO_ready       port -> control    1 = access completed / no access, 0 = replay
//   current_thread port -> datapath   thread owning this cycle's rden
//
// Optional (macro IO_READ_PORT_OVERRUN_CHECK_EN):
//   overrun_clear  producer -> port   clears all sticky overrun bits
//   overrun        port -> producer   sticky per-thread dropped-write flags
//
// Modports: slave = io_read_port, master = datapath / producer side.
// -----------------------------------------------------------------------------
interface io_read_port_if #(
   parameter int WORD_WIDTH        = 36,
   parameter int THREAD_COUNT      = 8,
   parameter int THREAD_ADDR_WIDTH = 3
);
   logic                         rden;
   logic                         ext_wren;
   logic [THREAD_ADDR_WIDTH-1:0] ext_thread;
   logic [WORD_WIDTH-1:0]        ext_data;
   logic [THREAD_COUNT-1:0]      ext_full;
   logic [WORD_WIDTH-1:0]        read_data;
   logic                         IO_ready;
   logic [THREAD_ADDR_WIDTH-1:0] current_thread;
`ifdef IO_READ_PORT_OVERRUN_CHECK_EN
   logic                         overrun_clear;
   logic [THREAD_COUNT-1:0]      overrun;

   modport slave (
      input  rden, ext_wren, ext_thread, ext_data, overrun_clear,
      output ext_full, read_data, IO_ready, current_thread, overrun
   );
   modport master (
      output rden, ext_wren, ext_thread, ext_data, overrun_clear,
      input  ext_full, read_data, IO_ready, current_thread, overrun
   );
`else
   modport slave (
      input  rden, ext_wren, ext_thread, ext_data,
      output ext_full, read_data, IO_ready, current_thread
   );
   modport master (
      output rden, ext_wren, ext_thread, ext_data,
      input  ext_full, read_data, IO_ready, current_thread
   );
`endif
endinterface

// File: rtl/io_read_port.sv
// -----------------------------------------------------------------------------
// io_read_port
// Responder end of the per-thread I/O stall handshake. Holds one single-entry
// receive buffer per hardware thread, filled by an external producer. A read
// by the current thread either returns the buffered word (IO_ready=1 the next
// cycle) or misses (IO_ready=0 the next cycle) so the PC controller replays
// that thread's instruction THREAD_COUNT cycles later.
//
// Ports:
//   clock    system clock, all state on the rising edge
//   reset_n  asynchronous active-low reset
//   port     io_read_port_if.slave (rden, ext_* write channel, ext_full,
//            read_data, IO_ready, current_thread)
//
// Optional feature: define IO_READ_PORT_OVERRUN_CHECK_EN to add sticky
// per-thread overrun flags (port.overrun) with a bulk clear
// (port.overrun_clear). Without it, writes to a full buffer drop silently.
// -----------------------------------------------------------------------------
module io_read_port #(
   parameter int WORD_WIDTH        = 36,
   parameter int THREAD_COUNT      = 8,
   parameter int THREAD_ADDR_WIDTH = 3,
   parameter int INITIAL_THREAD    = 0
) (
   input  logic          clock,
   input  logic          reset_n,
   io_read_port_if.slave port
);

   localparam logic [THREAD_ADDR_WIDTH-1:0] LAST_THREAD = THREAD_ADDR_WIDTH'(THREAD_COUNT - 1);
   localparam logic [THREAD_ADDR_WIDTH-1:0] FIRST_THREAD = THREAD_ADDR_WIDTH'(INITIAL_THREAD);

   logic [THREAD_ADDR_WIDTH-1:0] r_thread;
   logic [THREAD_COUNT-1:0]      r_full;
   logic [WORD_WIDTH-1:0]        r_buf [THREAD_COUNT];
   logic [WORD_WIDTH-1:0]        r_read_data;
   logic                         r_io_ready;

   logic                         w_thread_valid;
   logic                         w_hit;
   logic                         w_wr_en;
   logic [THREAD_COUNT-1:0]      w_full_nxt;

   // Free-running thread counter; it never stalls, replays are the
   // controller's business.
   // NOTE: sequential state is always assigned with <= so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         r_thread <= FIRST_THREAD;
      else if (r_thread == LAST_THREAD)
         r_thread <= '0;
      else
         r_thread <= r_thread + 1'b1;
   end

   assign w_thread_valid = (int'(port.ext_thread) < THREAD_COUNT);
   assign w_hit          = port.rden & r_full[r_thread];

   // A read hit needs the flag set and an accepted write needs it clear, so
   // the two can never target the same flag in one cycle. A write to a full
   // buffer (including the one being read this cycle) is dropped.
   // NOTE: every always_comb output gets a default first so no latch forms.
   always_comb begin
      w_full_nxt = r_full;
      w_wr_en    = 1'b0;
      if (port.ext_wren && w_thread_valid && !r_full[port.ext_thread]) begin
         w_wr_en                     = 1'b1;
         w_full_nxt[port.ext_thread] = 1'b1;
      end
      if (w_hit)
         w_full_nxt[r_thread] = 1'b0;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         r_full <= '0;
      else
         r_full <= w_full_nxt;
   end

   // NOTE: buffer storage has no reset; its contents only matter while the
   // matching full flag is set, and that flag is reset.
   always_ff @(posedge clock) begin
      if (w_wr_en)
         r_buf[port.ext_thread] <= port.ext_data;
   end

   // Registered read response, latency 1. read_data only moves on a hit;
   // IO_ready drops only for a miss.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_read_data <= '0;
         r_io_ready  <= 1'b1;
      end else begin
         r_io_ready <= ~port.rden | r_full[r_thread];
         if (w_hit)
            r_read_data <= r_buf[r_thread];
      end
   end

   assign port.current_thread = r_thread;
   assign port.ext_full       = r_full;
   assign port.read_data      = r_read_data;
   assign port.IO_ready       = r_io_ready;

`ifdef IO_READ_PORT_OVERRUN_CHECK_EN
   logic [THREAD_COUNT-1:0] r_overrun;
   logic [THREAD_COUNT-1:0] w_drop_vec;

   always_comb begin
      w_drop_vec = '0;
      if (port.ext_wren && w_thread_valid && r_full[port.ext_thread])
         w_drop_vec[port.ext_thread] = 1'b1;
   end

   // Set wins over a same-cycle clear so no violation is ever lost.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         r_overrun <= '0;
      else
         r_overrun <= (r_overrun & ~{THREAD_COUNT{port.overrun_clear}}) | w_drop_vec;
   end

   assign port.overrun = r_overrun;
`endif

endmodule

// File: tb/tb_io_read_port.sv
// -----------------------------------------------------------------------------
// tb_io_read_port
// Self-checking bench for io_read_port: a directed vector table from reset,
// an asynchronous mid-operation reset, then randomized traffic compared each
// cycle against a behavioural model of per-thread single-entry mailboxes.
// Define IO_READ_PORT_OVERRUN_CHECK_EN to also check the overrun flags.
// -----------------------------------------------------------------------------
module tb_io_read_port;

   localparam int WW  = 36;
   localparam int TC  = 8;
   localparam int TAW = 3;

   logic clock = 1'b0;
   logic reset_n;
   always #5 clock = ~clock;

   io_read_port_if #(.WORD_WIDTH(WW), .THREAD_COUNT(TC), .THREAD_ADDR_WIDTH(TAW)) bus ();

   io_read_port #(
      .WORD_WIDTH(WW), .THREAD_COUNT(TC), .THREAD_ADDR_WIDTH(TAW), .INITIAL_THREAD(0)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .port    (bus.slave)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rden, input logic wren, input logic [TAW-1:0] wthr,
                        input logic [WW-1:0] wdata, input logic clr);
      bus.rden       = rden;
      bus.ext_wren   = wren;
      bus.ext_thread = wthr;
      bus.ext_data   = wdata;
`ifdef IO_READ_PORT_OVERRUN_CHECK_EN
      bus.overrun_clear = clr;
`else
      if (clr) begin end
`endif
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // ---------------- behavioural model: one mailbox per thread ----------------
   bit [TC-1:0]   m_full;
   logic [WW-1:0] m_buf [TC];
   logic [WW-1:0] m_rd;
   bit            m_rdy;
   int            m_thr;
   bit [TC-1:0]   m_ovr;

   task automatic model_reset();
      m_full = '0; m_rd = '0; m_rdy = 1'b1; m_thr = 0; m_ovr = '0;
   endtask

   task automatic model_step(input bit rden, input bit wren, input logic [TAW-1:0] wt,
                             input logic [WW-1:0] wd, input bit clr);
      bit [TC-1:0] pre;
      pre = m_full;
      if (!rden)
         m_rdy = 1'b1;
      else if (pre[m_thr]) begin
         m_rd = m_buf[m_thr];
         m_rdy = 1'b1;
         m_full[m_thr] = 1'b0;
      end else
         m_rdy = 1'b0;
      if (clr) m_ovr = '0;
      if (wren) begin
         if (pre[wt]) m_ovr[wt] = 1'b1;
         else begin
            m_buf[wt]  = wd;
            m_full[wt] = 1'b1;
         end
      end
      m_thr = (m_thr + 1) % TC;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic           rden;
      logic           wren;
      logic [TAW-1:0] wthr;
      logic [WW-1:0]  wdata;
      logic           clr;
      logic           exp_rdy;
      logic [TC-1:0]  exp_full;
      logic [WW-1:0]  exp_rd;
      logic [TC-1:0]  exp_ovr;
   } vec_t;

   vec_t tbl [25];

   initial begin
      logic [63:0]    r64;
      logic           rr, rw, rc;
      logic [TAW-1:0] rt;
      logic [WW-1:0]  rdat;

      // row i is applied while current_thread == i % 8
      tbl[0]  = '{0, 1, 3, 36'hABC, 0, 1, 8'h08, 36'h0,   8'h00};
      tbl[1]  = '{0, 0, 0, 36'h0,   0, 1, 8'h08, 36'h0,   8'h00};
      tbl[2]  = '{0, 0, 0, 36'h0,   0, 1, 8'h08, 36'h0,   8'h00};
      tbl[3]  = '{1, 0, 0, 36'h0,   0, 1, 8'h00, 36'hABC, 8'h00};
      tbl[4]  = '{0, 0, 0, 36'h0,   0, 1, 8'h00, 36'hABC, 8'h00};
      tbl[5]  = '{1, 0, 0, 36'h0,   0, 0, 8'h00, 36'hABC, 8'h00};
      tbl[6]  = '{0, 1, 5, 36'h123, 0, 1, 8'h20, 36'hABC, 8'h00};
      tbl[7]  = '{0, 0, 0, 36'h0,   0, 1, 8'h20, 36'hABC, 8'h00};
      tbl[8]  = '{0, 0, 0, 36'h0,   0, 1, 8'h20, 36'hABC, 8'h00};
      tbl[9]  = '{0, 0, 0, 36'h0,   0, 1, 8'h20, 36'hABC, 8'h00};
      tbl[10] = '{1, 1, 2, 36'h55,  0, 0, 8'h24, 36'hABC, 8'h00};
      tbl[11] = '{0, 0, 0, 36'h0,   0, 1, 8'h24, 36'hABC, 8'h00};
      tbl[12] = '{0, 1, 6, 36'h11,  0, 1, 8'h64, 36'hABC, 8'h00};
      tbl[13] = '{1, 0, 0, 36'h0,   0, 1, 8'h44, 36'h123, 8'h00};
      tbl[14] = '{0, 1, 6, 36'h22,  0, 1, 8'h44, 36'h123, 8'h40};
      tbl[15] = '{0, 0, 0, 36'h0,   0, 1, 8'h44, 36'h123, 8'h40};
      tbl[16] = '{0, 0, 0, 36'h0,   1, 1, 8'h44, 36'h123, 8'h00};
      tbl[17] = '{0, 0, 0, 36'h0,   0, 1, 8'h44, 36'h123, 8'h00};
      tbl[18] = '{1, 0, 0, 36'h0,   0, 1, 8'h40, 36'h55,  8'h00};
      tbl[19] = '{0, 0, 0, 36'h0,   0, 1, 8'h40, 36'h55,  8'h00};
      tbl[20] = '{0, 0, 0, 36'h0,   0, 1, 8'h40, 36'h55,  8'h00};
      tbl[21] = '{0, 0, 0, 36'h0,   0, 1, 8'h40, 36'h55,  8'h00};
      tbl[22] = '{1, 1, 6, 36'h33,  1, 1, 8'h00, 36'h11,  8'h40};
      tbl[23] = '{1, 1, 1, 36'h77,  0, 0, 8'h02, 36'h11,  8'h40};
      tbl[24] = '{1, 1, 4, 36'h88,  0, 0, 8'h12, 36'h11,  8'h40};

      // ---------------- reset state ----------------
      reset_n = 1'b0;
      drive(0, 0, '0, '0, 0);
      @(negedge clock);
      check("reset ext_full", 64'(bus.ext_full), 64'h0);
      check("reset IO_ready", 64'(bus.IO_ready), 64'h1);
      check("reset read_data", 64'(bus.read_data), 64'h0);
      check("reset current_thread", 64'(bus.current_thread), 64'h0);
`ifdef IO_READ_PORT_OVERRUN_CHECK_EN
      check("reset overrun", 64'(bus.overrun), 64'h0);
`endif
      @(negedge clock);
      reset_n = 1'b1;

      // ---------------- directed table ----------------
      for (int i = 0; i < 25; i++) begin
         drive(tbl[i].rden, tbl[i].wren, tbl[i].wthr, tbl[i].wdata, tbl[i].clr);
         step();
         check($sformatf("row%0d current_thread", i), 64'(bus.current_thread), 64'((i + 1) % TC));
         check($sformatf("row%0d IO_ready", i), 64'(bus.IO_ready), 64'(tbl[i].exp_rdy));
         check($sformatf("row%0d ext_full", i), 64'(bus.ext_full), 64'(tbl[i].exp_full));
         check($sformatf("row%0d read_data", i), 64'(bus.read_data), 64'(tbl[i].exp_rd));
`ifdef IO_READ_PORT_OVERRUN_CHECK_EN
         check($sformatf("row%0d overrun", i), 64'(bus.overrun), 64'(tbl[i].exp_ovr));
`endif
      end

      // ---------------- asynchronous reset mid-operation ----------------
      // threads 1 and 4 full, IO_ready low, read_data nonzero at this point
      drive(0, 0, '0, '0, 0);
      #2;
      reset_n = 1'b0;
      #1;
      check("async ext_full", 64'(bus.ext_full), 64'h0);
      check("async IO_ready", 64'(bus.IO_ready), 64'h1);
      check("async read_data", 64'(bus.read_data), 64'h0);
      check("async current_thread", 64'(bus.current_thread), 64'h0);
`ifdef IO_READ_PORT_OVERRUN_CHECK_EN
      check("async overrun", 64'(bus.overrun), 64'h0);
`endif
      @(negedge clock);
      reset_n = 1'b1;
      model_reset();

      // ---------------- randomized traffic vs model ----------------
      for (int c = 0; c < 400; c++) begin
         r64  = {$urandom(), $urandom()};
         rdat = r64[WW-1:0];
         rr   = ($urandom_range(1, 0) == 1);
         rw   = ($urandom_range(1, 0) == 1);
         rc   = ($urandom_range(15, 0) == 0);
         rt   = TAW'($urandom_range(TC - 1, 0));
         drive(rr, rw, rt, rdat, rc);
         step();
         model_step(rr, rw, rt, rdat, rc);
         check($sformatf("rand%0d current_thread", c), 64'(bus.current_thread), 64'(m_thr));
         check($sformatf("rand%0d IO_ready", c), 64'(bus.IO_ready), 64'(m_rdy));
         check($sformatf("rand%0d ext_full", c), 64'(bus.ext_full), 64'(m_full));
         check($sformatf("rand%0d read_data", c), 64'(bus.read_data), 64'(m_rd));
`ifdef IO_READ_PORT_OVERRUN_CHECK_EN
         check($sformatf("rand%0d overrun", c), 64'(bus.overrun), 64'(m_ovr));
`endif
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
